// File: rtl/flex_packer_pkg.sv
// Shared definitions for flex_data_packer: firmware condition codes and config byte layout.
package flex_packer_pkg;

  typedef enum logic [7:0] {
    COND_NONE     = 8'd0,
    COND_LAST     = 8'd1,
    COND_NOTLAST  = 8'd2,
    COND_FIRST    = 8'd3,
    COND_NOTFIRST = 8'd4
  } cond_e;

  localparam logic [7:0] LEN_DISABLED = 8'd0;

  // Config stream: one cond byte per chain, then one len byte per chain.
  localparam int unsigned CFG_COND_BASE = 0;

  function automatic int unsigned cfg_len_base(input int unsigned max_chains);
    return CFG_COND_BASE + max_chains;
  endfunction

  function automatic int unsigned cfg_total_bytes(input int unsigned max_chains);
    return cfg_len_base(max_chains) + max_chains;
  endfunction

endpackage

// File: rtl/packer_fw_regs.sv
// Byte-serial firmware loader for flex_data_packer plus per-chain len/cond lookup.
module packer_fw_regs
  import flex_packer_pkg::*;
#(
  parameter int unsigned N                  = 8,
  parameter int unsigned MAX_CHAINS         = 4,
  parameter int unsigned PERSONAL_CONFIG_ID = 0,
  parameter logic [7:0]  INITIAL_FIRMWARE_LEN  [0:MAX_CHAINS-1] = '{default: 8'd0},
  parameter logic [7:0]  INITIAL_FIRMWARE_COND [0:MAX_CHAINS-1] = '{default: 8'd0}
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tracing,
  input  logic [7:0]                    configId,
  input  logic [7:0]                    configData,
  input  logic [$clog2(MAX_CHAINS)-1:0] chainId,
  input  logic                          eof,
  input  logic                          bof,
  output logic [$clog2(N+1)-1:0]        sel_len,
  output logic                          sel_ok
);

  localparam int unsigned CHW       = $clog2(MAX_CHAINS);
  localparam int unsigned LW        = $clog2(N+1);
  localparam int unsigned NBYTES    = cfg_total_bytes(MAX_CHAINS);
  localparam int unsigned BCW       = $clog2(NBYTES+1);
  localparam int unsigned LEN_BASE  = cfg_len_base(MAX_CHAINS);

  logic [7:0]     len_q  [0:MAX_CHAINS-1];
  logic [7:0]     cond_q [0:MAX_CHAINS-1];
  logic [BCW-1:0] byte_cnt_q;
  logic [7:0]     len_raw;
  logic [7:0]     cond_raw;

  // Chain count is a power of two, so the low counter bits index either table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= '0;
      for (int unsigned i = 0; i < MAX_CHAINS; i++) begin
        len_q[i]  <= INITIAL_FIRMWARE_LEN[i];
        cond_q[i] <= INITIAL_FIRMWARE_COND[i];
      end
    end else if (!tracing) begin
      if (configId == 8'(PERSONAL_CONFIG_ID)) begin
        if (byte_cnt_q < BCW'(NBYTES)) begin
          if (byte_cnt_q < BCW'(LEN_BASE))
            cond_q[byte_cnt_q[CHW-1:0]] <= configData;
          else
            len_q[byte_cnt_q[CHW-1:0]] <= configData;
          byte_cnt_q <= byte_cnt_q + BCW'(1);
        end
      end else begin
        byte_cnt_q <= '0;
      end
    end
  end

  always_comb begin
    len_raw  = len_q[chainId];
    cond_raw = cond_q[chainId];
    sel_len  = '0;
    if (len_raw != LEN_DISABLED && 32'(len_raw) <= N)
      sel_len = LW'(len_raw);
    case (cond_raw)
      COND_NONE:     sel_ok = 1'b1;
      COND_LAST:     sel_ok = eof;
      COND_NOTLAST:  sel_ok = !eof;
      COND_FIRST:    sel_ok = bof;
      COND_NOTFIRST: sel_ok = !bof;
      default:       sel_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/flex_data_packer.sv
// Packs 1..N-element chain vectors gap-free into N-wide outputs with a residue buffer.
// Optional flush of partial data is enabled with FLEX_PACKER_FLUSH_EN.
module flex_data_packer
  import flex_packer_pkg::*;
#(
  parameter int unsigned N                  = 8,
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned MAX_CHAINS         = 4,
  parameter int unsigned PERSONAL_CONFIG_ID = 0,
  parameter logic [7:0]  INITIAL_FIRMWARE_LEN  [0:MAX_CHAINS-1] = '{default: 8'd0},
  parameter logic [7:0]  INITIAL_FIRMWARE_COND [0:MAX_CHAINS-1] = '{default: 8'd0}
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tracing,
  input  logic                          valid_in,
  input  logic                          eof_in,
  input  logic                          bof_in,
  input  logic [$clog2(MAX_CHAINS)-1:0] chainId_in,
  input  logic                          flush_in,
  input  logic [7:0]                    configId,
  input  logic [7:0]                    configData,
  input  logic [DATA_WIDTH-1:0]         vector_in  [N-1:0],
  output logic [DATA_WIDTH-1:0]         vector_out [N-1:0],
  output logic [$clog2(N+1)-1:0]        count_out,
  output logic                          valid_out
);

  localparam int unsigned CW = $clog2(N);
  localparam int unsigned LW = $clog2(N+1);

  logic [LW-1:0]         fw_len;
  logic                  fw_ok;
  logic                  accept;
  logic                  full;
  logic                  flush_fire;
  int unsigned           take;
  int unsigned           fill;
  int unsigned           total;
  logic [CW-1:0]         c_q;
  logic [DATA_WIDTH-1:0] buf_q [0:N-2];
  logic [DATA_WIDTH-1:0] cat   [0:2*N-2];

  packer_fw_regs #(
    .N                     (N),
    .MAX_CHAINS            (MAX_CHAINS),
    .PERSONAL_CONFIG_ID    (PERSONAL_CONFIG_ID),
    .INITIAL_FIRMWARE_LEN  (INITIAL_FIRMWARE_LEN),
    .INITIAL_FIRMWARE_COND (INITIAL_FIRMWARE_COND)
  ) u_fw_regs (
    .clk        (clk),
    .rst_n      (rst_n),
    .tracing    (tracing),
    .configId   (configId),
    .configData (configData),
    .chainId    (chainId_in),
    .eof        (eof_in),
    .bof        (bof_in),
    .sel_len    (fw_len),
    .sel_ok     (fw_ok)
  );

  // cat = residue ++ accepted elements, zero past the valid total so the
  // buffer stays zero-padded and a flush can emit it directly.
  always_comb begin
    accept = tracing & valid_in & fw_ok & (fw_len != LW'(LEN_DISABLED));
    take   = accept ? 32'(fw_len) : 32'd0;
    fill   = 32'(c_q);
    total  = fill + take;
    for (int unsigned k = 0; k < 2*N-1; k++) cat[k] = '0;
    for (int unsigned k = 0; k < N-1; k++)
      if (k < fill) cat[k] = buf_q[k];
    for (int unsigned j = 0; j < N; j++)
      if (j < take) cat[fill+j] = vector_in[j];
    full = (total >= N);
  end

`ifdef FLEX_PACKER_FLUSH_EN
  logic flush_pending_q;

  // A flush yields to a full output and is retried the following cycle.
  assign flush_fire = (flush_in | flush_pending_q) & tracing & !full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flush_pending_q <= 1'b0;
    else        flush_pending_q <= (flush_in | flush_pending_q) & !flush_fire;
  end
`else
  logic unused_flush_in;
  assign unused_flush_in = flush_in;
  assign flush_fire      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      count_out <= '0;
      c_q       <= '0;
      for (int unsigned i = 0; i < N; i++)   vector_out[i] <= '0;
      for (int unsigned i = 0; i < N-1; i++) buf_q[i]      <= '0;
    end else if (full) begin
      valid_out <= 1'b1;
      count_out <= LW'(N);
      c_q       <= CW'(total - N);
      for (int unsigned i = 0; i < N; i++)   vector_out[i] <= cat[i];
      for (int unsigned i = 0; i < N-1; i++) buf_q[i]      <= cat[N+i];
    end else if (flush_fire) begin
      valid_out <= (total != 0);
      c_q       <= '0;
      if (total != 0) begin
        count_out <= LW'(total);
        for (int unsigned i = 0; i < N; i++) vector_out[i] <= cat[i];
      end
      for (int unsigned i = 0; i < N-1; i++) buf_q[i] <= '0;
    end else begin
      valid_out <= 1'b0;
      c_q       <= CW'(total);
      for (int unsigned i = 0; i < N-1; i++) buf_q[i] <= cat[i];
    end
  end

endmodule

// File: tb/tb_flex_data_packer.sv
// Table-driven bench for flex_data_packer (N=8, 32-bit, 4 chains, config id 5).
module tb_flex_data_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tracing, valid_in, eof_in, bof_in, flush_in;
  logic [1:0]  chainId_in;
  logic [7:0]  configId, configData;
  logic [31:0] vin  [7:0];
  logic [31:0] vout [7:0];
  logic [3:0]  count_out;
  logic        valid_out;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic         arst;
    logic         trc;
    logic         vld;
    logic         eof;
    logic         bof;
    logic         fl;
    logic [1:0]   ch;
    logic [7:0]   cid;
    logic [7:0]   cdat;
    logic [255:0] vin;
    logic         ev;
    logic [3:0]   ec;
    logic [255:0] eo;
  } row_t;

  row_t rows[$];

  flex_data_packer #(
    .N                     (8),
    .DATA_WIDTH            (32),
    .MAX_CHAINS            (4),
    .PERSONAL_CONFIG_ID    (5),
    .INITIAL_FIRMWARE_LEN  ('{8'd3, 8'd8, 8'd5, 8'd3}),
    .INITIAL_FIRMWARE_COND ('{8'd0, 8'd0, 8'd0, 8'd1})
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tracing    (tracing),
    .valid_in   (valid_in),
    .eof_in     (eof_in),
    .bof_in     (bof_in),
    .chainId_in (chainId_in),
    .flush_in   (flush_in),
    .configId   (configId),
    .configData (configData),
    .vector_in  (vin),
    .vector_out (vout),
    .count_out  (count_out),
    .valid_out  (valid_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] ramp(input int unsigned base, input int unsigned n);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (i < int'(n)) r[i*32 +: 32] = 32'(base + 32'(i));
    return r;
  endfunction

  function automatic logic [255:0] pk8(input int unsigned a0, a1, a2, a3, a4, a5, a6, a7);
    return {32'(a7), 32'(a6), 32'(a5), 32'(a4), 32'(a3), 32'(a2), 32'(a1), 32'(a0)};
  endfunction

  function automatic logic [255:0] vout_flat();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = vout[i];
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", nm, idx, got, exp);
    end
  endtask

  task automatic add(input logic arst, trc, vld, eof, fl, input logic [1:0] ch,
                     input logic [7:0] cid, cdat, input logic [255:0] v,
                     input logic ev, input logic [3:0] ec, input logic [255:0] eo);
    row_t r;
    r = '{arst: arst, trc: trc, vld: vld, eof: eof, bof: 1'b0, fl: fl, ch: ch,
          cid: cid, cdat: cdat, vin: v, ev: ev, ec: ec, eo: eo};
    rows.push_back(r);
  endtask

  task automatic acc(input logic [1:0] ch, input logic [255:0] v,
                     input logic ev, input logic [255:0] eo);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ch, 8'hFF, 8'h00, v, ev, 4'd8, eo);
  endtask

  task automatic cfg(input logic [7:0] cid, input logic [7:0] d);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, cid, d, ramp(500, 8), 1'b0, 4'd0, '0);
  endtask

  task automatic check_reset_state(input int idx);
    chk("rst_valid", idx, 256'(valid_out), 256'(0));
    chk("rst_count", idx, 256'(count_out), 256'(0));
    chk("rst_vector", idx, vout_flat(), '0);
  endtask

  initial begin
    // chain 0 len 3: 1..24 into three full vectors
    for (int i = 0; i < 8; i++)
      acc(2'd0, ramp(32'(3*i+1), 8), (i == 2 || i == 5 || i == 7),
          ramp((i == 2) ? 1 : (i == 5) ? 9 : 17, 8));
    // chain 1 len 8: pass-through with continuous valid_out
    for (int i = 0; i < 4; i++)
      acc(2'd1, ramp(32'(100 + 10*i), 8), 1'b1, ramp(32'(100 + 10*i), 8));
    // chain 2 len 5 twice, then flush
    acc(2'd2, ramp(1, 8), 1'b0, '0);
    acc(2'd2, ramp(6, 8), 1'b1, ramp(1, 8));
`ifdef FLEX_PACKER_FLUSH_EN
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 8'hFF, 8'h00, '0, 1'b1, 4'd2, ramp(9, 2));
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'hFF, 8'h00, '0, 1'b0, 4'd0, '0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 8'hFF, 8'h00, ramp(11, 8), 1'b1, 4'd5, ramp(11, 5));
    acc(2'd2, ramp(1, 8), 1'b0, '0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 8'hFF, 8'h00, ramp(6, 8), 1'b1, 4'd8, ramp(1, 8));
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'hFF, 8'h00, '0, 1'b1, 4'd2, ramp(9, 2));
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'hFF, 8'h00, '0, 1'b0, 4'd0, '0);
`else
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 8'hFF, 8'h00, '0, 1'b0, 4'd0, '0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'hFF, 8'h00, '0, 1'b0, 4'd0, '0);
`endif
    // chain 3 len 3 cond LAST, after a reset that discards any residue
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 8'hFF, 8'h00, ramp(50, 8), 1'b0, 4'd0, '0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 8'hFF, 8'h00, ramp(1, 8),  1'b0, 4'd0, '0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 8'hFF, 8'h00, ramp(60, 8), 1'b0, 4'd0, '0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 8'hFF, 8'h00, ramp(4, 8),  1'b0, 4'd0, '0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 8'hFF, 8'h00, ramp(7, 8),  1'b1, 4'd8, ramp(1, 8));
    // config: partial load, id change resets counter, full load, extra byte ignored
    cfg(8'd5, 8'd9); cfg(8'd5, 8'd9); cfg(8'hFF, 8'd0);
    for (int i = 0; i < 4; i++) cfg(8'd5, 8'd0);
    for (int i = 0; i < 4; i++) cfg(8'd5, 8'd2);
    cfg(8'd5, 8'd1);
    acc(2'd0, ramp(20, 8), 1'b0, '0);
    acc(2'd0, ramp(22, 8), 1'b0, '0);
    acc(2'd0, ramp(24, 8), 1'b0, '0);
    acc(2'd0, ramp(26, 8), 1'b1, pk8(9, 20, 21, 22, 23, 24, 25, 26));
    // reload: chain 1 cond 7 (never), chain 3 len 9 (> N, disabled)
    cfg(8'hFF, 8'd0);
    cfg(8'd5, 8'd0); cfg(8'd5, 8'd7); cfg(8'd5, 8'd0); cfg(8'd5, 8'd0);
    cfg(8'd5, 8'd2); cfg(8'd5, 8'd2); cfg(8'd5, 8'd2); cfg(8'd5, 8'd9);
    acc(2'd1, ramp(90, 8), 1'b0, '0);
    acc(2'd2, ramp(30, 8), 1'b0, '0);
    acc(2'd3, ramp(80, 8), 1'b0, '0);
    acc(2'd2, ramp(32, 8), 1'b0, '0);
    acc(2'd0, ramp(34, 8), 1'b0, '0);
    acc(2'd2, ramp(36, 8), 1'b1, pk8(27, 30, 31, 32, 33, 34, 35, 36));
    // async reset restores initial firmware and drops residue (c=1 here, c=6 below)
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'hFF, 8'h00, ramp(200, 8), 1'b1, 4'd8, ramp(200, 8));
    acc(2'd0, ramp(1, 8), 1'b0, '0);
    acc(2'd0, ramp(4, 8), 1'b0, '0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'hFF, 8'h00, ramp(300, 8), 1'b1, 4'd8, ramp(300, 8));
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'hFF, 8'h00, '0, 1'b0, 4'd0, '0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 8'hFF, 8'h00, '0, 1'b0, 4'd0, '0);

    rst_n = 1'b0; tracing = 1'b1; valid_in = 1'b0; eof_in = 1'b0; bof_in = 1'b0;
    flush_in = 1'b0; chainId_in = '0; configId = 8'hFF; configData = '0;
    for (int i = 0; i < 8; i++) vin[i] = '0;
    #12;
    check_reset_state(-1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < rows.size(); i++) begin
      if (rows[i].arst) begin
        #2 rst_n = 1'b0;
        #1 check_reset_state(i);
        @(negedge clk);
        rst_n = 1'b1;
      end
      tracing    = rows[i].trc;
      valid_in   = rows[i].vld;
      eof_in     = rows[i].eof;
      bof_in     = rows[i].bof;
      flush_in   = rows[i].fl;
      chainId_in = rows[i].ch;
      configId   = rows[i].cid;
      configData = rows[i].cdat;
      for (int e = 0; e < 8; e++) vin[e] = rows[i].vin[e*32 +: 32];
      @(negedge clk);
      chk("valid_out", i, 256'(valid_out), 256'(rows[i].ev));
      if (rows[i].ev) begin
        chk("count_out", i, 256'(count_out), 256'(rows[i].ec));
        chk("vector_out", i, vout_flat(), rows[i].eo);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flex_data_packer.md
# flex_data_packer

Parametrised successor to the fixed-mode trace packer. Accepts per-chain vectors of any length 1..N and packs them gap-free into full N-wide output vectors, spilling the remainder of an input into the next output. Supports an explicit flush of a partial vector with a valid count. Sits in the instrumentation chain between the filter/reduce stages and the trace buffer, reconfigured byte-serially while tracing is low.

## Interface
- N, 8, output vector width in elements (≥2)
- DATA_WIDTH, 32, element width in bits
- MAX_CHAINS, 4, number of firmware chains (power of 2)
- PERSONAL_CONFIG_ID, 0, configId value addressing this block
- INITIAL_FIRMWARE_LEN [0:MAX_CHAINS-1], all 0, per-chain vector length after reset
- INITIAL_FIRMWARE_COND [0:MAX_CHAINS-1], all 0, per-chain condition code after reset
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- tracing  in  1  1 = packing, 0 = configuration mode
- valid_in  in  1  vector_in valid
- eof_in / bof_in  in  1 each  last / first vector of frame
- chainId_in  in  $clog2(MAX_CHAINS)  selects firmware entry
- flush_in  in  1  request emission of partial data
- configId  in  8  configuration target id
- configData  in  8  configuration byte
- vector_in [N-1:0]  in  DATA_WIDTH each  input elements, index 0 first
- vector_out [N-1:0]  out  DATA_WIDTH each  packed output
- count_out  out  $clog2(N+1)  number of valid elements in vector_out (N unless flushed)
- valid_out  out  1  one-cycle pulse per output vector

## Operation
- Firmware per chain: len L (0 = disabled, 1..N = use vector_in[0..L-1], >N treated as 0); cond: 0 none, 1 last (eof_in=1), 2 notlast, 3 first (bof_in=1), 4 notfirst, other = never.
- Accept = tracing & valid_in & L≠0 & cond met for chainId_in.
- State: residue buffer of N-1 elements, count c (0..N-1); elements stored in arrival order from index 0.
- On accept, t = c+L. t<N: append, c←t, no output. t≥N: vector_out = buffer[0..c-1] ++ vector_in[0..N-c-1], count_out=N, valid_out=1; vector_in[N-c..L-1] moved to buffer[0..], c←t-N.
- flush_in sets flush_pending. Resolved in first cycle (including the flush cycle) with no full output: if c(after that cycle's accept)>0, emit buffer padded with zeros, count_out=c, c←0; if c=0, no output. Pending then clears.
- Accept + full output + flush same cycle: full output now, partial remainder next cycle (if no new full output).
- Config (tracing=0): configId==PERSONAL_CONFIG_ID writes byte at byte_counter: 0..MAX_CHAINS-1 → cond, MAX_CHAINS..2·MAX_CHAINS-1 → len; later bytes ignored; byte_counter saturates at 2·MAX_CHAINS. Any other configId resets byte_counter to 0. byte_counter unchanged while tracing=1.
- Residue and flush_pending persist across tracing=0 and firmware changes.

## Timing
- Registered outputs, latency 1 cycle from accepting edge to valid_out.
- Full throughput: one input per cycle, never stalls; no backpressure.
- Reset (any time, incl. mid-packing): valid_out=0, vector_out all 0, count_out=0, c=0, residue cleared, flush_pending=0, byte_counter=0, firmware = INITIAL_* values. Partial data is discarded.
- valid_out is 0 in every cycle without an emission, including all config-mode cycles.

## Configuration
- FLEX_PACKER_FLUSH_EN defined: flush_in behaves as above.
- Undefined: flush_in ignored, flush_pending logic absent, count_out constant N whenever valid_out=1.

## Structure
- Package flex_packer_pkg: cond code enum (COND_NONE..COND_NOTFIRST), LEN_DISABLED=0 constant, config byte layout offsets.
- Sub-module packer_fw_regs: byte-serial firmware loader + per-chain len/cond lookup and cond evaluation; datapath/residue logic in the top.

## Test plan
- N=8, chain len 3, eight accepts of values 1..24 → three outputs: {1..8},{9..16},{17..24}, count_out=8, c=0 at end.
- len 8 on chain 0 with c=0 → output equals input next cycle every cycle, continuous valid_out.
- len 5 twice (1..5, 6..10) then flush_in → {1..8} then {9,10,0,0,0,0,0,0} count_out=2.
- cond=1 (last): vectors with eof_in=0 ignored, eof_in=1 accepted; cond=7 → never accepted.
- tracing=0, configId=PERSONAL_CONFIG_ID, bytes {0,0,0,0,2,2,2,2} → all chains len 2; configId change mid-stream resets byte_counter; reload verified.
- rst_n asserted asynchronously with c=6 → outputs zero immediately, next 8-element vector output alone, no stale residue.
